// File: rtl/seq_stream_checker.sv
// rtl/seq_stream_checker.sv - incrementing addr/data stream checker with error capture
module seq_stream_checker #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16,
  parameter int NUM_SAMPLES   = 1024
) (
  input  logic                     clk,
  input  logic                     sys_rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [ADDR_WIDTH-1:0]    in_addr,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic [DATA_WIDTH-1:0]    first_err_data,
  output logic [23:0]              sample_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_CHECK,
    S_DONE
  } state_t;

  // 25 bits so the legal maximum of 2^24 samples is representable
  localparam logic [24:0] LP_NUM_SAMPLES = 25'(NUM_SAMPLES);

  state_t                   r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]    r_exp_addr, w_exp_addr_nxt;
  logic [DATA_WIDTH-1:0]    r_exp_data, w_exp_data_nxt;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt, w_err_cnt_nxt;
  logic [ADDR_WIDTH-1:0]    r_first_err_addr, w_first_err_addr_nxt;
  logic [DATA_WIDTH-1:0]    r_first_err_data, w_first_err_data_nxt;
  logic [23:0]              r_sample_cnt, w_sample_cnt_nxt;
  logic                     r_busy, w_busy_nxt;
  logic                     r_done, w_done_nxt;
  logic                     r_pass, w_pass_nxt;

  logic                     w_mismatch;
  logic [24:0]              w_cnt_inc;

  assign w_mismatch = (in_addr != r_exp_addr) || (in_data != r_exp_data);
  assign w_cnt_inc  = {1'b0, r_sample_cnt} + 25'd1;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt          = r_state;
    w_exp_addr_nxt       = r_exp_addr;
    w_exp_data_nxt       = r_exp_data;
    w_err_cnt_nxt        = r_err_cnt;
    w_first_err_addr_nxt = r_first_err_addr;
    w_first_err_data_nxt = r_first_err_data;
    w_sample_cnt_nxt     = r_sample_cnt;
    w_busy_nxt           = r_busy;
    w_done_nxt           = r_done;
    w_pass_nxt           = r_pass;

    // start wins over everything, including a sample in the same cycle
    if (start) begin
      w_state_nxt          = S_SYNC;
      w_err_cnt_nxt        = '0;
      w_first_err_addr_nxt = '0;
      w_first_err_data_nxt = '0;
      w_sample_cnt_nxt     = '0;
      w_busy_nxt           = 1'b1;
      w_done_nxt           = 1'b0;
      w_pass_nxt           = 1'b0;
    end else begin
      case (r_state)
        S_SYNC: begin
          if (in_valid) begin
            w_exp_addr_nxt   = in_addr + ADDR_WIDTH'(1);
            w_exp_data_nxt   = in_data + DATA_WIDTH'(1);
            w_sample_cnt_nxt = 24'd1;
            w_state_nxt      = S_CHECK;
          end
        end
        S_CHECK: begin
          if (in_valid) begin
            if (w_mismatch) begin
              if (r_err_cnt == '0) begin
                w_first_err_addr_nxt = in_addr;
                w_first_err_data_nxt = in_data;
              end
              if (!(&r_err_cnt)) begin
                w_err_cnt_nxt = r_err_cnt + ERR_CNT_WIDTH'(1);
              end
            end
            w_exp_addr_nxt   = in_addr + ADDR_WIDTH'(1);
            w_exp_data_nxt   = in_data + DATA_WIDTH'(1);
            w_sample_cnt_nxt = w_cnt_inc[23:0];
            if (w_cnt_inc == LP_NUM_SAMPLES) begin
              w_state_nxt = S_DONE;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_pass_nxt  = (w_err_cnt_nxt == '0);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_exp_addr       <= '0;
      r_exp_data       <= '0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
      r_first_err_data <= '0;
      r_sample_cnt     <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
    end else begin
      r_exp_addr       <= w_exp_addr_nxt;
      r_exp_data       <= w_exp_data_nxt;
      r_err_cnt        <= w_err_cnt_nxt;
      r_first_err_addr <= w_first_err_addr_nxt;
      r_first_err_data <= w_first_err_data_nxt;
      r_sample_cnt     <= w_sample_cnt_nxt;
      r_busy           <= w_busy_nxt;
      r_done           <= w_done_nxt;
      r_pass           <= w_pass_nxt;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err_addr;
  assign first_err_data = r_first_err_data;
  assign sample_cnt     = r_sample_cnt;

endmodule

// File: tb/tb_seq_stream_checker.sv
// tb/tb_seq_stream_checker.sv - directed-vector bench for seq_stream_checker
module tb_seq_stream_checker;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int EW = 2;
  localparam int NS = 8;

  logic          clk;
  logic          sys_rst_n;
  logic          start;
  logic          in_valid;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic [EW-1:0] err_cnt;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_data;
  logic [23:0]   sample_cnt;

  int n_checks;
  int n_errors;

  seq_stream_checker #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .ERR_CNT_WIDTH(EW),
    .NUM_SAMPLES  (NS)
  ) u_dut (
    .clk           (clk),
    .sys_rst_n     (sys_rst_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_err_addr(first_err_addr),
    .first_err_data(first_err_data),
    .sample_cnt    (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // inputs change on the falling edge; outputs are read on the next falling edge
  task automatic send(input int a, input int d);
    in_valid = 1'b1;
    in_addr  = AW'(a);
    in_data  = DW'(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    sys_rst_n = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    repeat (2) @(negedge clk);

    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err", 32'(err_cnt), 0);
    check("rst_cnt", 32'(sample_cnt), 0);
    sys_rst_n = 1'b1;
    @(negedge clk);

    send(3, 3);
    check("idle_ignore_cnt", 32'(sample_cnt), 0);
    check("idle_ignore_busy", 32'(busy), 0);

    // clean run
    pulse_start();
    check("clean_busy", 32'(busy), 1);
    for (int i = 0; i < 7; i++) send(i, i);
    check("clean_not_done", 32'(done), 0);
    send(7, 7);
    check("clean_done", 32'(done), 1);
    check("clean_busy_low", 32'(busy), 0);
    check("clean_pass", 32'(pass), 1);
    check("clean_err", 32'(err_cnt), 0);
    check("clean_cnt", 32'(sample_cnt), 8);
    send(8, 8);
    check("done_hold", 32'(done), 1);
    check("done_ignore_cnt", 32'(sample_cnt), 8);

    // single jump
    pulse_start();
    check("restart_done_clr", 32'(done), 0);
    send(0, 0); send(1, 1); send(5, 5);
    for (int i = 6; i <= 10; i++) send(i, i);
    check("jump_done", 32'(done), 1);
    check("jump_err", 32'(err_cnt), 1);
    check("jump_fa", 32'(first_err_addr), 5);
    check("jump_fd", 32'(first_err_data), 5);
    check("jump_pass", 32'(pass), 0);

    // data-only error with 4-bit wrap
    pulse_start();
    send(14, 14); send(15, 15); send(0, 0);
    check("wrap_err0", 32'(err_cnt), 0);
    send(1, 3); send(2, 4);
    check("wrap_err1", 32'(err_cnt), 1);
    check("wrap_fa", 32'(first_err_addr), 1);
    check("wrap_fd", 32'(first_err_data), 3);
    send(3, 5); send(4, 6); send(5, 7);
    check("wrap_done", 32'(done), 1);
    check("wrap_pass", 32'(pass), 0);

    // saturation: every +2 step is a mismatch
    pulse_start();
    send(0, 0);
    for (int i = 1; i <= 6; i++) send(2 * i, 2 * i);
    check("sat_err", 32'(err_cnt), 3);
    check("sat_fa", 32'(first_err_addr), 2);
    check("sat_fd", 32'(first_err_data), 2);
    check("sat_cnt", 32'(sample_cnt), 7);
    check("sat_busy", 32'(busy), 1);

    // start collides with a sample mid-CHECK
    start    = 1'b1;
    in_valid = 1'b1;
    in_addr  = 4'd3;
    in_data  = 4'd3;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    check("coll_cnt", 32'(sample_cnt), 0);
    check("coll_err", 32'(err_cnt), 0);
    check("coll_fa", 32'(first_err_addr), 0);
    check("coll_busy", 32'(busy), 1);
    check("coll_done", 32'(done), 0);
    send(9, 3); send(10, 4);
    check("coll_seed_err", 32'(err_cnt), 0);
    check("coll_seed_cnt", 32'(sample_cnt), 2);

    // async reset between edges during CHECK
    send(12, 12);
    check("pre_rst_err", 32'(err_cnt), 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_err", 32'(err_cnt), 0);
    check("arst_cnt", 32'(sample_cnt), 0);
    check("arst_fa", 32'(first_err_addr), 0);
    check("arst_fd", 32'(first_err_data), 0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 9; i++) send(i, i);
    check("post_rst_cnt", 32'(sample_cnt), 0);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_done", 32'(done), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
